// File: rtl/dequantize_pkg.sv
// Types and constants shared by the dequantiser, its interface and its bench.
package dequantize_pkg;
`include "sys_defs.svh"

  localparam int CH   = `CH;
  localparam int CH_W = $clog2(`CH + 1);

  typedef logic [7:0][7:0][11:0] blk_in_t;
  typedef logic [7:0][7:0][15:0] blk_out_t;
  typedef logic [7:0][15:0]      row_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } dq_state_e;
endpackage

// File: rtl/dequantize_if.sv
// Block in/out handshake bundle; slave is the dequantiser side.
interface dequantize_if;
  import dequantize_pkg::*;

  blk_in_t         block_in;
  logic            valid_in;
  logic [CH_W-1:0] ch_in;
  logic            ready_in;
  QUANT_PACKET     qp;
  blk_out_t        block_out;
  logic [CH_W-1:0] ch_out;
  logic            valid_out;
  logic            ready_out;

  modport slave (
    input  block_in, valid_in, ch_in, qp, ready_out,
    output ready_in, block_out, ch_out, valid_out
  );

  modport master (
    output block_in, valid_in, ch_in, qp, ready_out,
    input  ready_in, block_out, ch_out, valid_out
  );
endinterface

// File: rtl/dequantize_mult_sat.sv
// One coefficient: signed 12-bit x unsigned 8-bit step, saturated to signed 16.
module dq_mult_sat (
  input  logic [11:0] coef,
  input  logic [7:0]  q,
  output logic [15:0] res
);
  logic signed [20:0] prod;

  // Zero-extending the step keeps it positive inside a signed multiply.
  assign prod = $signed(coef) * $signed({1'b0, q});

  always_comb begin
    res = prod[15:0];
    if (prod > 21'sd32767)
      res = 16'h7fff;
    else if (prod < -21'sd32768)
      res = 16'h8000;
  end
endmodule

// File: rtl/sys_defs.svh
// Shared system definitions: channel count and the quantisation packet layout.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define CH 3

typedef struct packed {
  logic [1:0][7:0][7:0][7:0] qt;   // two 8x8 tables of unsigned 8-bit steps
  logic [`CH-1:0]            map;  // per-channel table select
} QUANT_PACKET;

`endif

// File: rtl/dequantize.sv
// Dequantises an 8x8 block one row per cycle through 8 column multipliers.
module dequantize
  import dequantize_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dequantize_if.slave  dq
);
  dq_state_e       state, state_nxt;
  blk_in_t         blk_q;
  logic [CH_W-1:0] ch_q;
  logic            tab_q;
  logic [2:0]      row_q;
  blk_out_t        out_q;
  row_out_t        row_res;
  logic            rdy;
  logic            accept;

  assign accept       = dq.valid_in && rdy;
  assign dq.ready_in  = rdy;
  assign dq.valid_out = (state == DONE);
  assign dq.block_out = out_q;
  assign dq.ch_out    = ch_q;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (dq.valid_in)
          state_nxt = CALC;
      end
      CALC: begin
        if (row_q == 3'd7)
          state_nxt = DONE;
      end
      DONE: begin
        // Handing off and accepting the next block share one edge.
        rdy = dq.ready_out;
        if (dq.ready_out)
          state_nxt = dq.valid_in ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar c = 0; c < 8; c++) begin : g_col
    dq_mult_sat u_mult (
      .coef (blk_q[row_q][c]),
      .q    (dq.qp.qt[tab_q][row_q][c]),
      .res  (row_res[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_q <= '0;
      ch_q  <= '0;
      tab_q <= 1'b0;
      row_q <= 3'd0;
      out_q <= '0;
    end else if (accept) begin
      blk_q <= dq.block_in;
      ch_q  <= dq.ch_in;
      tab_q <= dq.qp.map[dq.ch_in];
      row_q <= 3'd0;
    end else if (state == CALC) begin
      out_q[row_q] <= row_res;
      row_q        <= row_q + 3'd1;
    end
  end
endmodule
